// File: rtl/cve2_fetch_realign_buffer_pkg.sv
// Shared types and helpers for the fetch realign buffer and its word FIFO.
package cve2_fetch_realign_buffer_pkg;

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } fetch_entry_t;

   function automatic logic is_compressed(input logic [1:0] opc);
      return opc != 2'b11;
   endfunction

endpackage

// File: rtl/cve2_fetch_fifo.sv
// Shift-style word FIFO with flush; head is always entry 0, next is entry 1.
module cve2_fetch_fifo
   import cve2_fetch_realign_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 3,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [31:0]      push_data_i,
   input  logic             push_err_i,
   input  logic             pop_i,
   output logic [31:0]      head_data_o,
   output logic             head_err_o,
   output logic [31:0]      next_data_o,
   output logic             next_err_o,
   output logic [CNT_W-1:0] count_o
);

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [CNT_W-1:0] cnt_q, cnt_d, wr_idx;

   always_comb begin
      mem_d  = mem_q;
      cnt_d  = cnt_q;
      wr_idx = cnt_q - CNT_W'(pop_i);
      if (flush_i) begin
         cnt_d = '0;
      end else begin
         if (pop_i) begin
            for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
         end
         // a simultaneous pop frees the slot below the current tail
         if (push_i) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (CNT_W'(i) == wr_idx) mem_d[i] = '{err: push_err_i, data: push_data_i};
            end
         end
         cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         cnt_q <= cnt_d;
         mem_q <= mem_d;
      end
   end

   always @(posedge clk_i) begin
      if (rst_ni && !flush_i) begin
         assert (!(push_i && !pop_i && cnt_q == CNT_W'(DEPTH)));
         assert (!(pop_i && cnt_q == '0));
      end
   end

   assign head_data_o = mem_q[0].data;
   assign head_err_o  = mem_q[0].err;
   assign next_data_o = mem_q[1].data;
   assign next_err_o  = mem_q[1].err;
   assign count_o     = cnt_q;

endmodule

// File: rtl/cve2_fetch_realign_buffer.sv
// Fetch front end: OBI request/outstanding tracking, word buffering and halfword realignment
// presenting one 16- or 32-bit instruction per handshake.
module cve2_fetch_realign_buffer
   import cve2_fetch_realign_buffer_pkg::*;
#(
   parameter int unsigned DEPTH           = 3,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   input  logic        branch_i,
   input  logic [31:0] addr_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [31:0] rdata_o,
   output logic [31:0] addr_o,
   output logic        err_o,
   output logic        err_plus2_o,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic        instr_err_i,
   output logic        busy_o
);

   localparam int unsigned FCNT_W = $clog2(DEPTH + 1);
   localparam int unsigned OCNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned SUM_W  = $clog2(DEPTH + MAX_OUTSTANDING + 1);

   logic [FCNT_W-1:0]          fifo_cnt;
   logic [31:0]                e0_data, e1_data;
   logic                       e0_err, e1_err;
   logic [OCNT_W-1:0]          oc_q, oc_d, oc_ret;
   logic [MAX_OUTSTANDING-1:0] disc_q, disc_d;
   logic [31:0]                fetch_addr_q, fetch_addr_d, addr_q, addr_d;
   logic                       offset_q, offset_d;
   logic [SUM_W-1:0]           occupancy;
   logic                       gnt, push, pop, fire, e0_vld, e1_vld, uncomp1, comp;
   logic                       unused_bits;

   cve2_fetch_fifo #(.DEPTH(DEPTH), .CNT_W(FCNT_W)) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (branch_i),
      .push_i      (push),
      .push_data_i (instr_rdata_i),
      .push_err_i  (instr_err_i),
      .pop_i       (pop),
      .head_data_o (e0_data),
      .head_err_o  (e0_err),
      .next_data_o (e1_data),
      .next_err_o  (e1_err),
      .count_o     (fifo_cnt)
   );

   // A branch empties the FIFO this cycle, so only in-flight requests occupy space
   assign occupancy    = (branch_i ? '0 : SUM_W'(fifo_cnt)) + SUM_W'(oc_q);
   assign instr_req_o  = req_i & (oc_q < OCNT_W'(MAX_OUTSTANDING)) & (occupancy < SUM_W'(DEPTH));
   assign instr_addr_o = branch_i ? {addr_i[31:2], 2'b00} : fetch_addr_q;
   assign gnt          = instr_req_o & instr_gnt_i;
   assign busy_o       = instr_req_o | (oc_q != '0);
   assign push         = instr_rvalid_i & ~disc_q[0] & ~branch_i;

   always_comb begin
      fetch_addr_d = fetch_addr_q;
      if (gnt)           fetch_addr_d = instr_addr_o + 32'd4;
      else if (branch_i) fetch_addr_d = {addr_i[31:2], 2'b00};
   end

   // Discard bits are ordered oldest-first: index 0 belongs to the next response
   always_comb begin
      oc_ret = oc_q - OCNT_W'(instr_rvalid_i);
      disc_d = branch_i ? '1 : disc_q;
      if (instr_rvalid_i) begin
         for (int i = 0; i < MAX_OUTSTANDING - 1; i++) disc_d[i] = disc_d[i+1];
         disc_d[MAX_OUTSTANDING-1] = 1'b0;
      end
      if (gnt) begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (OCNT_W'(i) == oc_ret) disc_d[i] = 1'b0;
         end
      end
      oc_d = oc_ret + OCNT_W'(gnt);
   end

   assign e0_vld  = fifo_cnt != '0;
   assign e1_vld  = fifo_cnt > FCNT_W'(1);
   assign uncomp1 = offset_q & ~is_compressed(e0_data[17:16]);

   always_comb begin
      rdata_o = e0_data;
      if (offset_q) rdata_o = uncomp1 ? {e1_data[15:0], e0_data[31:16]} : {16'h0, e0_data[31:16]};
   end

   // An errored head is presented on its own so the error is not stuck behind a missing e1
   assign valid_o     = e0_vld & (~uncomp1 | e1_vld | e0_err);
   assign err_o       = e0_vld & (e0_err | (uncomp1 & e1_vld & e1_err));
   assign err_plus2_o = e0_vld & ~e0_err & uncomp1 & e1_vld & e1_err;
   assign addr_o      = addr_q;

   assign comp = is_compressed(rdata_o[1:0]);
   assign fire = valid_o & ready_i & ~branch_i;
   assign pop  = fire & (offset_q | ~comp);

   always_comb begin
      addr_d   = addr_q;
      offset_d = offset_q;
      if (branch_i) begin
         addr_d   = {addr_i[31:1], 1'b0};
         offset_d = addr_i[1];
      end else if (fire) begin
         addr_d   = addr_q + (comp ? 32'd2 : 32'd4);
         offset_d = offset_q ^ comp;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         oc_q         <= '0;
         disc_q       <= '0;
         fetch_addr_q <= '0;
         addr_q       <= '0;
         offset_q     <= 1'b0;
      end else begin
         oc_q         <= oc_d;
         disc_q       <= disc_d;
         fetch_addr_q <= fetch_addr_d;
         addr_q       <= addr_d;
         offset_q     <= offset_d;
      end
   end

   assign unused_bits = ^{addr_i[0], e1_data[31:16]};

endmodule

// File: tb/tb_cve2_fetch_realign_buffer.sv
// Bench for cve2_fetch_realign_buffer: directed scenarios plus randomized bus/IF traffic checked
// against an instruction-stream model derived from a memory image.
module tb_cve2_fetch_realign_buffer;

   logic        clk_i = 1'b0;
   logic        rst_ni, req_i, branch_i, ready_i;
   logic [31:0] addr_i;
   logic        valid_o, err_o, err_plus2_o, instr_req_o, busy_o;
   logic [31:0] rdata_o, addr_o, instr_addr_o;
   logic        instr_gnt_i, instr_rvalid_i, instr_err_i;
   logic [31:0] instr_rdata_i;

   cve2_fetch_realign_buffer dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
      .ready_i(ready_i), .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o), .err_o(err_o),
      .err_plus2_o(err_plus2_o), .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
      .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
      .instr_err_i(instr_err_i), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   int unsigned errors = 0;
   int unsigned checks = 0;
   logic [31:0] ovr_d [logic [31:0]];
   bit          ovr_e [logic [31:0]];
   bit          err_en = 1'b0;
   logic [31:0] pend [$];
   logic [31:0] exp_pc = 32'h0;
   int          hs = 0;
   logic        obs_valid, obs_req, obs_busy, obs_err, obs_err2;
   logic [31:0] obs_addr, obs_rdata, obs_iaddr;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      if (ovr_d.exists(a)) return ovr_d[a];
      return (a * 32'h9E3779B1) ^ (a >> 3) ^ 32'h5A5A3C3C;
   endfunction

   function automatic bit mem_err(input logic [31:0] a);
      if (ovr_e.exists(a)) return ovr_e[a];
      return err_en && ((a >> 2) % 13 == 5);
   endfunction

   function automatic logic [15:0] hw(input logic [31:0] a);
      logic [31:0] w;
      w = mem_data({a[31:2], 2'b00});
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   function automatic bit is_c(input logic [31:0] a);
      logic [15:0] h;
      h = hw(a);
      return h[1:0] != 2'b11;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive IF-side inputs and bus responses, then check against the model.
   task automatic cyc(input bit rdy, input bit br, input logic [31:0] ba, input bit rq,
                      input int gp, input int rp);
      logic [31:0] a, exp_rd, mask;
      bit          c, e0e, e1e;
      @(negedge clk_i);
      ready_i = rdy; branch_i = br; addr_i = ba; req_i = rq;
      instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
      if (pend.size() > 0 && int'($urandom_range(99)) < rp) begin
         a = pend.pop_front();
         instr_rvalid_i = 1'b1;
         instr_rdata_i  = mem_data(a);
         instr_err_i    = mem_err(a);
      end
      #1;
      obs_req = instr_req_o; obs_iaddr = instr_addr_o; obs_valid = valid_o; obs_busy = busy_o;
      obs_addr = addr_o; obs_rdata = rdata_o; obs_err = err_o; obs_err2 = err_plus2_o;
      if (instr_req_o) begin
         chk("iaddr_align", 32'(instr_addr_o[1:0]), 32'h0);
         if (int'($urandom_range(99)) < gp) begin
            instr_gnt_i = 1'b1;
            pend.push_back(instr_addr_o);
         end
      end
      if (valid_o) begin
         c      = is_c(exp_pc);
         e0e    = mem_err({exp_pc[31:2], 2'b00});
         a      = exp_pc + 32'd2;
         e1e    = mem_err({a[31:2], 2'b00});
         exp_rd = {hw(exp_pc + 32'd2), hw(exp_pc)};
         mask   = (c || e0e) ? 32'h0000FFFF : 32'hFFFFFFFF;
         chk("m_addr", addr_o, exp_pc);
         chk("m_rdata", rdata_o & mask, exp_rd & mask);
         chk("m_err", 32'(err_o), 32'(e0e | (!c & e1e)));
         chk("m_err2", 32'(err_plus2_o), 32'(!e0e & !c & e1e));
      end
      if (valid_o && ready_i && !branch_i) begin
         exp_pc = exp_pc + (is_c(exp_pc) ? 32'd2 : 32'd4);
         hs++;
      end
      if (branch_i) exp_pc = {ba[31:1], 1'b0};
   endtask

   task automatic drain();
      int n = 0;
      while (pend.size() > 0 && n < 20) begin
         cyc(1'b0, 1'b0, 32'h0, 1'b0, 0, 100);
         n++;
      end
      chk("drain_bound", 32'(pend.size()), 32'h0);
   endtask

   bit          rbr;
   logic [31:0] rba;

   initial begin
      ovr_d[32'h100] = 32'h00A00093;
      ovr_d[32'h180] = 32'h45010001; ovr_d[32'h184] = 32'h00000000;
      ovr_d[32'h1C4] = 32'h00930001; ovr_d[32'h1C8] = 32'h00000000; ovr_e[32'h1C8] = 1'b1;
      ovr_d[32'h200] = 32'h00400513; ovr_d[32'h300] = 32'hDEADBEEF; ovr_d[32'h304] = 32'hCAFEF00D;
      for (int k = 0; k < 4; k++) ovr_d[32'h400 + 32'(4 * k)] = 32'h00000013 | (32'(k) << 20);

      rst_ni = 1'b0; req_i = 1'b0; branch_i = 1'b0; addr_i = '0; ready_i = 1'b0;
      instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_valid", 32'(valid_o), 32'h0);
      chk("rst_req", 32'(instr_req_o), 32'h0);
      chk("rst_busy", 32'(busy_o), 32'h0);
      chk("rst_addr", addr_o, 32'h0);
      chk("rst_iaddr", instr_addr_o, 32'h0);
      chk("rst_err", 32'({err_o, err_plus2_o}), 32'h0);
      rst_ni = 1'b1;

      // Aligned 32-bit instruction, zero-wait bus
      cyc(1'b0, 1'b1, 32'h100, 1'b1, 100, 0);
      chk("t1_req", 32'(obs_req), 32'h1);
      chk("t1_iaddr", obs_iaddr, 32'h100);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 100, 100);
      chk("t1_no_valid_on_rvalid", 32'(obs_valid), 32'h0);
      cyc(1'b1, 1'b0, 32'h0, 1'b1, 0, 0);
      chk("t1_valid", 32'(obs_valid), 32'h1);
      chk("t1_addr", obs_addr, 32'h100);
      chk("t1_rdata", obs_rdata, 32'h00A00093);
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 0, 0);
      chk("t1_addr_next", obs_addr, 32'h104);

      // Unaligned compressed instruction does not wait for the next word
      drain();
      cyc(1'b0, 1'b1, 32'h182, 1'b1, 100, 0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 100, 100);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 0, 0);
      chk("t2_valid", 32'(obs_valid), 32'h1);
      chk("t2_rdata", 32'(obs_rdata[15:0]), 32'h4501);
      chk("t2_addr", obs_addr, 32'h182);
      chk("t2_second_pending", 32'(pend.size()), 32'h1);

      // Unaligned 32-bit instruction whose upper half faults
      drain();
      cyc(1'b0, 1'b1, 32'h1C6, 1'b1, 100, 0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 100, 100);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 0, 0);
      chk("t3_wait_e1", 32'(obs_valid), 32'h0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 0, 100);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 0, 0);
      chk("t3_valid", 32'(obs_valid), 32'h1);
      chk("t3_err", 32'(obs_err), 32'h1);
      chk("t3_err2", 32'(obs_err2), 32'h1);
      chk("t3_addr", obs_addr, 32'h1C6);

      // Branch with two requests in flight drops both responses
      drain();
      cyc(1'b0, 1'b1, 32'h300, 1'b1, 100, 0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 100, 0);
      cyc(1'b0, 1'b1, 32'h200, 1'b1, 100, 100);
      chk("t4_req_full", 32'(obs_req), 32'h0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 100, 100);
      chk("t4_drop_a", 32'(obs_valid), 32'h0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 100, 100);
      chk("t4_drop_b", 32'(obs_valid), 32'h0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 0, 0);
      chk("t4_valid", 32'(obs_valid), 32'h1);
      chk("t4_addr", obs_addr, 32'h200);
      chk("t4_rdata", obs_rdata, 32'h00400513);

      // Backpressure: requests stop once buffered + in-flight reaches DEPTH
      drain();
      cyc(1'b0, 1'b1, 32'h400, 1'b1, 100, 100);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, 1'b0, 32'h0, 1'b1, 100, 100);
         if (k >= 2) chk("t5_req_held", 32'(obs_req), 32'h0);
      end
      chk("t5_busy", 32'(obs_busy), 32'h0);
      chk("t5_valid", 32'(obs_valid), 32'h1);
      cyc(1'b1, 1'b0, 32'h0, 1'b1, 100, 100);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 100, 100);
      chk("t5_resume", 32'(obs_req), 32'h1);

      // Reset with one request in flight and two buffered words
      drain();
      cyc(1'b0, 1'b1, 32'h500, 1'b1, 100, 100);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 100, 100);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 100, 100);
      chk("t6_pre_busy", 32'(obs_busy), 32'h1);
      @(negedge clk_i);
      rst_ni = 1'b0; req_i = 1'b0; branch_i = 1'b0; ready_i = 1'b0;
      instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_err_i = 1'b0;
      pend.delete();
      #1;
      chk("t6_valid", 32'(valid_o), 32'h0);
      chk("t6_busy", 32'(busy_o), 32'h0);
      chk("t6_req", 32'(instr_req_o), 32'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 0, 0);
      chk("t6_post_valid", 32'(obs_valid), 32'h0);
      chk("t6_post_addr", obs_addr, 32'h0);

      // Randomized traffic with sporadic bus errors and redirects
      err_en = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         rbr = (c == 0) || ($urandom_range(79) == 0);
         rba = 32'h1000 + 32'(2 * $urandom_range(1023));
         cyc($urandom_range(3) != 0, rbr, rba, $urandom_range(9) != 0, 70, 60);
      end
      chk("rand_progress", 32'(hs > 200), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
